// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles every non-clock/reset signal of the fetch sequencer: the redirect
//   input from the PC next-address logic, the instruction-memory request and
//   response channels, and the decode-side delivery channel.
//
//   Handshake semantics (all channels, single clock, rising edge):
//     - imem request : a transfer happens in a cycle where imem_req_valid and
//       imem_req_ready are both high. While imem_req_valid is high and ready is
//       low, imem_req_addr is held unless a redirect is taken.
//     - imem response: imem_rsp_valid is a one-cycle pulse carrying
//       imem_rsp_data for the single outstanding request. It has no ready.
//     - decode       : instr/instr_pc are held stable while instr_valid is
//       high. The word is consumed in a cycle where instr_valid is high and
//       stall is low.
//     - redirect     : redirect_valid is a one-cycle command. It takes effect
//       on the next clock edge.
//
//   Modports:
//     master - the fetch sequencer.
//     slave  - the environment: memory, decode and next-PC logic.
`timescale 1ns/1ps

interface fetch_sequencer_if #(
  parameter int PC_Size = 32
);
  logic               redirect_valid;
  logic [PC_Size-1:0] redirect_pc;
  logic               stall;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_Size-1:0] imem_req_addr;
  logic               imem_rsp_valid;
  logic [31:0]        imem_rsp_data;
  logic               instr_valid;
  logic [31:0]        instr;
  logic [PC_Size-1:0] instr_pc;
  logic               misalign_trap;

  modport master (
    input  redirect_valid, redirect_pc, stall,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_req_addr,
    output instr_valid, instr, instr_pc, misalign_trap
  );

  modport slave (
    output redirect_valid, redirect_pc, stall,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_req_addr,
    input  instr_valid, instr, instr_pc, misalign_trap
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multi-cycle instruction-fetch controller. It owns the architectural PC and
//   keeps at most one instruction-memory request outstanding. Fetched words
//   are presented to decode with their PC. A redirect replaces the PC on the
//   next edge. If a request is already in flight, its response is marked
//   stale through the kill flag and dropped when it returns.
//
//   Ports:
//     clk       - clock, rising edge
//     rst_n     - asynchronous active-low reset
//     bus       - fetch_sequencer_if.master (redirect, imem req/rsp, decode)
//     state_dbg - current FSM state encoding (BOOT=0 REQ=1 WAIT=2
//                 DELIVER=3 HALT=4)
//
//   Parameters:
//     PC_Size      - width of PC and memory address
//     RESET_VECTOR - PC loaded on reset
//
//   Build option:
//     FETCH_SEQUENCER_MISALIGN_TRAP_EN
//       When defined, a taken redirect whose target has nonzero low bits
//       halts fetch and raises a sticky misalign_trap. When undefined, the low
//       two bits of the target are cleared on load and misalign_trap is 0.
`timescale 1ns/1ps

module fetch_sequencer #(
  parameter int                 PC_Size      = 32,
  parameter logic [PC_Size-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_sequencer_if.master   bus,
  output logic [2:0]          state_dbg
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3
`ifdef FETCH_SEQUENCER_MISALIGN_TRAP_EN
    , S_HALT  = 3'd4
`endif
  } state_t;

  state_t             state, state_next;
  logic [PC_Size-1:0] pc, pc_next;
  logic [PC_Size-1:0] redir_tgt;
  logic               kill, kill_next;
  logic               load_instr;
  logic               req_valid_q;
  logic               instr_valid_q;
  logic [31:0]        instr_q;
  logic [PC_Size-1:0] instr_pc_q;

`ifdef FETCH_SEQUENCER_MISALIGN_TRAP_EN
  logic trap_q, trap_next;
  // The faulting target is kept exactly as received.
  assign redir_tgt = bus.redirect_pc;
`else
  // Targets are forced to word alignment.
  assign redir_tgt = bus.redirect_pc & ~PC_Size'(3);
`endif

  // Next-state, next-PC and kill-flag logic.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    kill_next  = kill;
    load_instr = 1'b0;
`ifdef FETCH_SEQUENCER_MISALIGN_TRAP_EN
    trap_next  = trap_q;
`endif

    case (state)
      S_BOOT: begin
        state_next = S_REQ;
        if (bus.redirect_valid) pc_next = redir_tgt;
      end

      S_REQ: begin
        if (bus.imem_req_ready) begin
          state_next = S_WAIT;
          // The request just accepted fetches the old PC. If we redirect in
          // the same cycle, its response must be thrown away.
          if (bus.redirect_valid) begin
            pc_next   = redir_tgt;
            kill_next = 1'b1;
          end
        end else if (bus.redirect_valid) begin
          pc_next = redir_tgt;
        end
      end

      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          // The response always retires the outstanding request, so the kill
          // flag is cleared whether or not the data is kept.
          kill_next = 1'b0;
          if (bus.redirect_valid) begin
            pc_next    = redir_tgt;
            state_next = S_REQ;
          end else if (kill) begin
            state_next = S_REQ;
          end else begin
            state_next = S_DELIVER;
            load_instr = 1'b1;
          end
        end else if (bus.redirect_valid) begin
          pc_next   = redir_tgt;
          kill_next = 1'b1;
        end
      end

      S_DELIVER: begin
        // A redirect takes priority over stall.
        if (bus.redirect_valid) begin
          pc_next    = redir_tgt;
          state_next = S_REQ;
        end else if (!bus.stall) begin
          pc_next    = pc + PC_Size'(4);
          state_next = S_REQ;
        end
      end

`ifdef FETCH_SEQUENCER_MISALIGN_TRAP_EN
      S_HALT: begin
        state_next = S_HALT;
      end
`endif

      default: begin
        state_next = S_BOOT;
      end
    endcase

`ifdef FETCH_SEQUENCER_MISALIGN_TRAP_EN
    // A misaligned target overrides the normal transition from any live
    // state. The PC keeps the faulting address for inspection.
    if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00) &&
        (state != S_HALT)) begin
      state_next = S_HALT;
      pc_next    = redir_tgt;
      kill_next  = 1'b0;
      load_instr = 1'b0;
      trap_next  = 1'b1;
    end
`endif
  end

  // State, PC and registered outputs. Output flags are computed from the next
  // state so that they line up with the state register without decode logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_BOOT;
      pc            <= RESET_VECTOR;
      kill          <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP;
      instr_pc_q    <= RESET_VECTOR;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      kill          <= kill_next;
      req_valid_q   <= (state_next == S_REQ);
      instr_valid_q <= (state_next == S_DELIVER);
      if (load_instr) begin
        instr_q    <= bus.imem_rsp_data;
        // In WAIT without a redirect, pc still holds the request address.
        instr_pc_q <= pc;
      end
    end
  end

`ifdef FETCH_SEQUENCER_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_next;
  end
  assign bus.misalign_trap = trap_q;
`else
  assign bus.misalign_trap = 1'b0;
`endif

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
  assign state_dbg          = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps

module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0100;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_Size(32)) bus ();

  fetch_sequencer #(
    .PC_Size      (32),
    .RESET_VECTOR (RV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.stall          = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset values
    chk("rst_state",       32'(state_dbg),         32'd0);
    chk("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid),    32'd0);
    chk("rst_instr",       bus.instr,               32'h0000_0013);
    chk("rst_instr_pc",    bus.instr_pc,            RV);
    chk("rst_trap",        32'(bus.misalign_trap),  32'd0);
    chk("rst_addr",        bus.imem_req_addr,       RV);

    // boot and first fetch
    rst_n = 1'b1;
    chk("boot_state", 32'(state_dbg), 32'd0);
    step();
    chk("req1_state", 32'(state_dbg), 32'd1);
    chk("req1_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("req1_addr",  bus.imem_req_addr, RV);
    step();
    chk("wait1_state", 32'(state_dbg), 32'd2);
    chk("wait1_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hAAAA_0001;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("dlv1_valid", 32'(bus.instr_valid), 32'd1);
    chk("dlv1_instr", bus.instr, 32'hAAAA_0001);
    chk("dlv1_pc",    bus.instr_pc, RV);

    // stall holds the delivered word for five cycles
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_instr", bus.instr, 32'hAAAA_0001);
      chk("stall_pc",    bus.instr_pc, RV);
      chk("stall_noreq", 32'(bus.imem_req_valid), 32'd0);
    end
    bus.stall = 1'b0;
    step();
    chk("req2_state", 32'(state_dbg), 32'd1);
    chk("req2_addr",  bus.imem_req_addr, 32'h0000_0104);
    chk("req2_ivld",  32'(bus.instr_valid), 32'd0);

    // memory not ready: request and address hold
    bus.imem_req_ready = 1'b0;
    step();
    chk("hold_state", 32'(state_dbg), 32'd1);
    chk("hold_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("hold_addr",  bus.imem_req_addr, 32'h0000_0104);
    bus.imem_req_ready = 1'b1;
    step();
    chk("wait2_state", 32'(state_dbg), 32'd2);

    // redirect in WAIT, coinciding with the response: response dropped
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_0000;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    chk("rdw_state", 32'(state_dbg), 32'd1);
    chk("rdw_ivld",  32'(bus.instr_valid), 32'd0);
    chk("rdw_addr",  bus.imem_req_addr, 32'h0000_0200);
    step();
    chk("rdw_wait", 32'(state_dbg), 32'd2);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBBBB_0002;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("rdw_dlv_valid", 32'(bus.instr_valid), 32'd1);
    chk("rdw_dlv_instr", bus.instr, 32'hBBBB_0002);
    chk("rdw_dlv_pc",    bus.instr_pc, 32'h0000_0200);
    step();
    chk("req3_addr", bus.imem_req_addr, 32'h0000_0204);
    step();
    chk("wait3_state", 32'(state_dbg), 32'd2);

    // redirect in WAIT before the response: later response killed
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    step();
    bus.redirect_valid = 1'b0;
    chk("kill_state", 32'(state_dbg), 32'd2);
    chk("kill_addr",  bus.imem_req_addr, 32'h0000_0300);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hCAFE_0000;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("kill_drop_state", 32'(state_dbg), 32'd1);
    chk("kill_drop_ivld",  32'(bus.instr_valid), 32'd0);
    chk("kill_drop_addr",  bus.imem_req_addr, 32'h0000_0300);
    chk("kill_drop_instr", bus.instr, 32'hBBBB_0002);

    // redirect in REQ while not ready, then PC wrap
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    chk("wrap_req_state", 32'(state_dbg), 32'd1);
    chk("wrap_req_addr",  bus.imem_req_addr, 32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    step();
    chk("wrap_wait", 32'(state_dbg), 32'd2);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hCCCC_0003;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("wrap_dlv_pc",    bus.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_dlv_instr", bus.instr, 32'hCCCC_0003);
    step();
    chk("wrap_state", 32'(state_dbg), 32'd1);
    chk("wrap_addr",  bus.imem_req_addr, 32'h0000_0000);

    // redirect beats stall in DELIVER
    step();
    chk("rbs_wait", 32'(state_dbg), 32'd2);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDDDD_0004;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("rbs_dlv_pc", bus.instr_pc, 32'h0000_0000);
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0400;
    step();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("rbs_state", 32'(state_dbg), 32'd1);
    chk("rbs_ivld",  32'(bus.instr_valid), 32'd0);
    chk("rbs_addr",  bus.imem_req_addr, 32'h0000_0400);

    // redirect in REQ on the accepting cycle: accepted then killed
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0500;
    step();
    bus.redirect_valid = 1'b0;
    chk("racc_state", 32'(state_dbg), 32'd2);
    chk("racc_addr",  bus.imem_req_addr, 32'h0000_0500);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hEEEE_0005;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("racc_drop_state", 32'(state_dbg), 32'd1);
    chk("racc_drop_ivld",  32'(bus.instr_valid), 32'd0);
    chk("racc_drop_addr",  bus.imem_req_addr, 32'h0000_0500);
    chk("racc_drop_instr", bus.instr, 32'hDDDD_0004);

    // reset mid-WAIT, late response after release
    step();
    chk("mrst_wait", 32'(state_dbg), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mrst_state", 32'(state_dbg), 32'd0);
    chk("mrst_rvld",  32'(bus.imem_req_valid), 32'd0);
    chk("mrst_instr", bus.instr, 32'h0000_0013);
    chk("mrst_addr",  bus.imem_req_addr, RV);
    step();
    rst_n              = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0BAD_0000;
    step();
    chk("mrst_req_state", 32'(state_dbg), 32'd1);
    chk("mrst_req_addr",  bus.imem_req_addr, RV);
    step();
    chk("mrst_ign_state", 32'(state_dbg), 32'd1);
    chk("mrst_ign_ivld",  32'(bus.instr_valid), 32'd0);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    step();
    chk("mrst_wait2", 32'(state_dbg), 32'd2);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1111_0000;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("mrst_dlv_pc",    bus.instr_pc, RV);
    chk("mrst_dlv_instr", bus.instr, 32'h1111_0000);
    step();
    chk("mrst_next_addr", bus.imem_req_addr, 32'h0000_0104);

    // misaligned redirect
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0202;
    step();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_SEQUENCER_MISALIGN_TRAP_EN
    chk("mis_state", 32'(state_dbg), 32'd4);
    chk("mis_trap",  32'(bus.misalign_trap), 32'd1);
    chk("mis_rvld",  32'(bus.imem_req_valid), 32'd0);
    chk("mis_addr",  bus.imem_req_addr, 32'h0000_0202);
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_rvld",  32'(bus.imem_req_valid), 32'd0);
      chk("halt_trap",  32'(bus.misalign_trap), 32'd1);
      chk("halt_ivld",  32'(bus.instr_valid), 32'd0);
      chk("halt_state", 32'(state_dbg), 32'd4);
    end
`else
    chk("mis_state", 32'(state_dbg), 32'd1);
    chk("mis_trap",  32'(bus.misalign_trap), 32'd0);
    chk("mis_rvld",  32'(bus.imem_req_valid), 32'd1);
    chk("mis_addr",  bus.imem_req_addr, 32'h0000_0200);
    bus.imem_req_ready = 1'b1;
    step();
    chk("mis_wait", 32'(state_dbg), 32'd2);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h2222_0000;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("mis_dlv_pc", bus.instr_pc, 32'h0000_0200);
`endif

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
